// File: rtl/jrb8_spi_pkg.sv
// Shared types and constants for the SPI memory controller.
package jrb8_spi_pkg;

  typedef enum logic [1:0] {
    ROM_RD = 2'b00,
    RAM_RD = 2'b01,
    RAM_WR = 2'b10,
    RSVD   = 2'b11
  } spi_op_t;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    FINISH,
    RELEASE
  } spi_state_t;

  localparam logic [7:0] SPI_CMD_READ  = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE = 8'h02;

  // The shifter is sized for the longest frame (ROM read); shorter frames
  // are left-justified so the command byte always leaves first.
  localparam int SHIFT_W        = 40;
  localparam int CMD_BITS       = 8;
  localparam int DATA_BITS      = 8;
  localparam int ROM_ADDR_BITS  = 24;
  localparam int ROM_FRAME_BITS = CMD_BITS + ROM_ADDR_BITS + DATA_BITS;

  // Bit-counter reload value for a field of the given length.
  function automatic logic [5:0] field_last(input int bits);
    return 6'(bits - 1);
  endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// MSB-first parallel-load output shifter plus serial-in capture for MISO.
module spi_shift_reg
  import jrb8_spi_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               shift_i,
  input  logic [SHIFT_W-1:0] load_val_i,
  input  logic               miso_i,
  output logic               mosi_o,
  output logic [7:0]         byte_o
);

  logic [SHIFT_W-1:0] sr_q;
  logic [6:0]         cap_q;

  // Load a whole frame at start, then move one bit out per SCLK period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else if (load_i) begin
      sr_q <= load_val_i;
    end else if (shift_i) begin
      sr_q <= {sr_q[SHIFT_W-2:0], 1'b0};
    end
  end

  // Collect MISO on the edges that drop SCLK; only the last seven bits are kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q <= '0;
    end else if (shift_i) begin
      cap_q <= {cap_q[5:0], miso_i};
    end
  end

  assign mosi_o = sr_q[SHIFT_W-1];
  // Byte as it will stand once the current MISO bit is taken in.
  assign byte_o = {cap_q, miso_i};

endmodule

// File: rtl/spi_mem_ctrl.sv
// Single-byte SPI transaction engine for serial flash (ROM) and serial RAM.
//
// state   | meaning
// IDLE    | waiting for a request, chip selects high
// CMD     | shifting the 8-bit command
// ADDR    | shifting the address (24 bits ROM, RAM_ADDR_BITS RAM)
// DATA    | shifting write data out or read data in
// FINISH  | CS released, spi_done high until request is dropped
// RELEASE | one idle cycle before a new request is accepted
module spi_mem_ctrl
  import jrb8_spi_pkg::*;
#(
  parameter logic [7:0] ROM_ADDR_HI   = 8'h00,
  parameter int         RAM_ADDR_BITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_executing,
  input  logic [1:0]  op,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic        spi_done,
  output logic [7:0]  rdata,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        rom_cs_n,
  output logic        ram_cs_n
);

  spi_state_t state_q;
  spi_op_t    op_q;
  logic [5:0] bit_cnt_q;
  logic       sclk_q;
  logic       rom_cs_n_q;
  logic       ram_cs_n_q;
  logic       done_q;
  logic [7:0] rdata_q;

  spi_op_t                  op_in;
  logic                     start;
  logic                     load_en;
  logic                     shift_en;
  logic [7:0]               cmd_byte;
  logic [7:0]               data_byte;
  logic [RAM_ADDR_BITS-1:0] ram_addr;
  logic [SHIFT_W-1:0]       frame_d;
  logic [7:0]               rx_byte;

  // Start decode and frame image; the frame is loaded on the start edge itself.
  always_comb begin
    op_in     = spi_op_t'(op);
    start     = (state_q == IDLE) && spi_executing && !done_q;
    load_en   = start && (op_in != RSVD);
    shift_en  = ((state_q == CMD) || (state_q == ADDR) || (state_q == DATA)) && sclk_q;
    cmd_byte  = (op_in == RAM_WR) ? SPI_CMD_WRITE : SPI_CMD_READ;
    data_byte = (op_in == RAM_WR) ? wdata : 8'h00;
    ram_addr  = RAM_ADDR_BITS'(addr);
    if (op_in == ROM_RD) begin
      frame_d = {cmd_byte, ROM_ADDR_HI, addr, data_byte};
    end else begin
      frame_d = SHIFT_W'({cmd_byte, ram_addr, data_byte}) << (ROM_ADDR_BITS - RAM_ADDR_BITS);
    end
  end

  spi_shift_reg u_shift (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load_en),
    .shift_i    (shift_en),
    .load_val_i (frame_d),
    .miso_i     (spi_miso),
    .mosi_o     (spi_mosi),
    .byte_o     (rx_byte)
  );

  // Sequencer: SCLK phase, per-field bit counter, chip selects and handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= ROM_RD;
      bit_cnt_q  <= '0;
      sclk_q     <= 1'b0;
      rom_cs_n_q <= 1'b1;
      ram_cs_n_q <= 1'b1;
      done_q     <= 1'b0;
      rdata_q    <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q <= op_in;
            if (op_in == RSVD) begin
              state_q <= FINISH;
              done_q  <= 1'b1;
            end else begin
              state_q    <= CMD;
              bit_cnt_q  <= field_last(CMD_BITS);
              sclk_q     <= 1'b0;
              rom_cs_n_q <= (op_in != ROM_RD);
              ram_cs_n_q <= (op_in == ROM_RD);
            end
          end
        end
        CMD, ADDR, DATA: begin
          sclk_q <= ~sclk_q;
          // A bit ends on the edge that takes SCLK back low.
          if (sclk_q) begin
            if (bit_cnt_q != 6'd0) begin
              bit_cnt_q <= bit_cnt_q - 6'd1;
            end else begin
              case (state_q)
                CMD: begin
                  state_q   <= ADDR;
                  bit_cnt_q <= (op_q == ROM_RD) ? field_last(ROM_ADDR_BITS)
                                                : field_last(RAM_ADDR_BITS);
                end
                ADDR: begin
                  state_q   <= DATA;
                  bit_cnt_q <= field_last(DATA_BITS);
                end
                default: begin
                  state_q    <= FINISH;
                  rom_cs_n_q <= 1'b1;
                  ram_cs_n_q <= 1'b1;
                  done_q     <= 1'b1;
                  if (op_q != RAM_WR) begin
                    rdata_q <= rx_byte;
                  end
                end
              endcase
            end
          end
        end
        FINISH: begin
          if (!spi_executing) begin
            state_q <= RELEASE;
            done_q  <= 1'b0;
          end
        end
        RELEASE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign spi_done = done_q;
  assign rdata    = rdata_q;
  assign spi_sclk = sclk_q;
  assign rom_cs_n = rom_cs_n_q;
  assign ram_cs_n = ram_cs_n_q;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Directed bench for spi_mem_ctrl with a behavioural SPI slave.
module tb_spi_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_executing = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  wdata = 8'h00;
  logic        spi_done;
  logic [7:0]  rdata;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_miso = 1'b0;
  logic        rom_cs_n;
  logic        ram_cs_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_mem_ctrl #(
    .ROM_ADDR_HI   (8'h00),
    .RAM_ADDR_BITS (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .spi_executing (spi_executing),
    .op            (op),
    .addr          (addr),
    .wdata         (wdata),
    .spi_done      (spi_done),
    .rdata         (rdata),
    .spi_sclk      (spi_sclk),
    .spi_mosi      (spi_mosi),
    .spi_miso      (spi_miso),
    .rom_cs_n      (rom_cs_n),
    .ram_cs_n      (ram_cs_n)
  );

  typedef struct {
    logic [1:0]  op;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  miso;
    int          drop_at;
    int          hold;
    int          lat;
    int          rom_low;
    int          ram_low;
    int          sclk_hi;
    logic [39:0] frame;
    logic [7:0]  rdata;
    int          done_w;
  } vec_t;

  vec_t vecs[7];

  task automatic check_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_f(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One request with slave model; intervals counted from the start edge.
  task automatic run_txn(
    input  logic [1:0]  t_op,
    input  logic [15:0] t_addr,
    input  logic [7:0]  t_wdata,
    input  logic [7:0]  t_miso,
    input  int          drop_at,
    input  int          hold,
    output int          lat,
    output int          rom_low,
    output int          ram_low,
    output int          sclk_hi,
    output logic [39:0] frame,
    output logic [7:0]  rd,
    output int          done_w,
    output int          fall,
    output int          overlap
  );
    int  n;
    int  j;
    int  k;
    bit  got;
    n       = (t_op == 2'b00) ? 40 : 32;
    lat     = 0;
    rom_low = 0;
    ram_low = 0;
    sclk_hi = 0;
    frame   = '0;
    rd      = 8'h00;
    overlap = 0;
    got     = 1'b0;
    j       = 0;
    @(negedge clk);
    op            = t_op;
    addr          = t_addr;
    wdata         = t_wdata;
    spi_executing = 1'b1;
    @(posedge clk);
    #1;
    op    = ~t_op;
    addr  = ~t_addr;
    wdata = ~t_wdata;
    while (!got && j < 200) begin
      @(negedge clk);
      j++;
      if (j == drop_at) spi_executing = 1'b0;
      if (!rom_cs_n) rom_low++;
      if (!ram_cs_n) ram_low++;
      if (!rom_cs_n && !ram_cs_n) overlap++;
      if (spi_sclk) begin
        sclk_hi++;
        frame = {frame[38:0], spi_mosi};
      end else if (!rom_cs_n || !ram_cs_n) begin
        k = (j - 1) / 2;
        if (k >= n - 8 && k < n) spi_miso = t_miso[3'(n - 1 - k)];
        else spi_miso = 1'b0;
      end
      if (spi_done) begin
        got = 1'b1;
        lat = j;
        rd  = rdata;
      end
    end
    done_w = got ? 1 : 0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (spi_done) done_w++;
      if (!rom_cs_n) rom_low++;
      if (!ram_cs_n) ram_low++;
      if (spi_sclk) sclk_hi++;
    end
    spi_executing = 1'b0;
    fall = 0;
    while (spi_done && fall < 10) begin
      @(negedge clk);
      fall++;
      if (spi_done) done_w++;
    end
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int          lat, rl, ml, sh, dw, fl, ov;
    logic [39:0] fr;
    logic [7:0]  rd;

    //           op     addr      wd     miso   drop hold lat rom ram sclk frame              rdata  dw
    vecs[0] = '{2'b00, 16'h1234, 8'h00, 8'hA5, 0,   0,   81, 80, 0,  40, 40'h0300123400, 8'hA5, 1};
    vecs[1] = '{2'b10, 16'h00FF, 8'h3C, 8'h5A, 0,   0,   65, 0,  64, 32, 40'h000200FF3C, 8'hA5, 1};
    vecs[2] = '{2'b01, 16'h00FF, 8'h00, 8'h3C, 0,   0,   65, 0,  64, 32, 40'h000300FF00, 8'h3C, 1};
    vecs[3] = '{2'b11, 16'hBEEF, 8'h77, 8'hFF, 0,   0,   1,  0,  0,  0,  40'h0000000000, 8'h3C, 1};
    vecs[4] = '{2'b00, 16'hFFFF, 8'h00, 8'h81, 0,   0,   81, 80, 0,  40, 40'h0300FFFF00, 8'h81, 1};
    vecs[5] = '{2'b01, 16'h8001, 8'h00, 8'h7E, 20,  0,   65, 0,  64, 32, 40'h0003800100, 8'h7E, 1};
    vecs[6] = '{2'b10, 16'h0000, 8'hFF, 8'h00, 0,   10,  65, 0,  64, 32, 40'h00020000FF, 8'h7E, 11};

    repeat (3) @(negedge clk);
    check_i("rst_rom_cs_n", int'(rom_cs_n), 1);
    check_i("rst_ram_cs_n", int'(ram_cs_n), 1);
    check_i("rst_sclk", int'(spi_sclk), 0);
    check_i("rst_mosi", int'(spi_mosi), 0);
    check_i("rst_done", int'(spi_done), 0);
    check_i("rst_rdata", int'(rdata), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].miso,
              vecs[i].drop_at, vecs[i].hold, lat, rl, ml, sh, fr, rd, dw, fl, ov);
      check_i($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check_i($sformatf("v%0d_rom_cs_low", i), rl, vecs[i].rom_low);
      check_i($sformatf("v%0d_ram_cs_low", i), ml, vecs[i].ram_low);
      check_i($sformatf("v%0d_sclk_high", i), sh, vecs[i].sclk_hi);
      check_f($sformatf("v%0d_mosi_frame", i), fr, vecs[i].frame);
      check_i($sformatf("v%0d_rdata", i), int'(rd), int'(vecs[i].rdata));
      check_i($sformatf("v%0d_done_width", i), dw, vecs[i].done_w);
      check_i($sformatf("v%0d_done_fall", i), fl, 1);
      check_i($sformatf("v%0d_cs_overlap", i), ov, 0);
    end

    // Reset in the middle of a ROM frame.
    @(negedge clk);
    op            = 2'b00;
    addr          = 16'h4321;
    spi_executing = 1'b1;
    @(posedge clk);
    for (int j = 0; j < 30; j++) @(negedge clk);
    check_i("midrst_pre_rom_cs_n", int'(rom_cs_n), 0);
    check_i("midrst_pre_sclk", int'(spi_sclk), 1);
    rst_n = 1'b0;
    #1;
    check_i("midrst_rom_cs_n", int'(rom_cs_n), 1);
    check_i("midrst_ram_cs_n", int'(ram_cs_n), 1);
    check_i("midrst_sclk", int'(spi_sclk), 0);
    check_i("midrst_rdata", int'(rdata), 0);
    check_i("midrst_done", int'(spi_done), 0);
    spi_executing = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_txn(2'b00, 16'h1234, 8'h00, 8'hA5, 0, 0, lat, rl, ml, sh, fr, rd, dw, fl, ov);
    check_i("postrst_latency", lat, 81);
    check_i("postrst_rom_cs_low", rl, 80);
    check_i("postrst_ram_cs_low", ml, 0);
    check_f("postrst_mosi_frame", fr, 40'h0300123400);
    check_i("postrst_rdata", int'(rd), 8'hA5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
